// File: rtl/simon_stream_bridge_pkg.sv
// Shared types and helpers for the SIMON_96144 stream bridge.
//
// Contents:
//   N_DEFAULT / W_DEFAULT : default SIMON word size and stream word width
//   block_t               : one SIMON block as two N-bit words, [1] is the MS word
//   in_state_t            : input (packer) FSM states
//   out_state_t           : output (unpacker) FSM states
//   words_per_block()     : number of stream words in one 2N-bit block
package simon_stream_bridge_pkg;

    localparam int N_DEFAULT = 48;
    localparam int W_DEFAULT = 16;

    typedef logic [1:0][N_DEFAULT-1:0] block_t;

    typedef enum logic {
        FILL,
        OFFER
    } in_state_t;

    typedef enum logic [1:0] {
        WAIT,
        ACK,
        DRAIN
    } out_state_t;

    // W is expected to divide 2N exactly; there is no partial-block handling.
    function automatic int words_per_block(input int n, input int w);
        return (2 * n) / w;
    endfunction

endpackage

// File: rtl/simon_stream_bridge_if.sv
// Bus bundle between the stream bridge, its stream source/sink and the SIMON core.
//
// Signals:
//   in_word/in_valid/in_ready     upstream W-bit word stream into the bridge
//   out_word/out_valid/out_ready  downstream W-bit result stream out of the bridge
//   blockIN/newData/loadData      block offer handshake towards the core
//   outData/doneData/readData     result return handshake from the core
//
// Modports:
//   slave  : the bridge's view
//   master : the surrounding system's view (stream source, sink and core)
interface simon_stream_bridge_if #(
    parameter int N = 48,
    parameter int W = 16
);

    logic [W-1:0]        in_word;
    logic                in_valid;
    logic                in_ready;

    logic [W-1:0]        out_word;
    logic                out_valid;
    logic                out_ready;

    logic [1:0][N-1:0]   blockIN;
    logic                newData;
    logic                loadData;

    logic [1:0][N-1:0]   outData;
    logic                doneData;
    logic                readData;

    modport slave (
        input  in_word, in_valid, out_ready, loadData, doneData, outData,
        output in_ready, out_word, out_valid, blockIN, newData, readData
    );

    modport master (
        output in_word, in_valid, out_ready, loadData, doneData, outData,
        input  in_ready, out_word, out_valid, blockIN, newData, readData
    );

endinterface

// File: rtl/simon_word_shifter.sv
// Parameterised W-bit-in / TOTAL-bit parallel-load shift register.
// Used as the packer (words shift in at the LS end, so the first word ends up
// in the MS position) and as the unpacker (parallel load, then the MS word is
// presented and the register shifts left one word per transfer).
//
// Ports:
//   clk, rst   clock and synchronous active-high reset (clears the register)
//   load       parallel load of load_data; wins over shift_en
//   load_data  TOTAL-bit value for the parallel load
//   shift_en   shift left by W, shift_in enters at the LS end
//   shift_in   W-bit word shifted in
//   data       top OUT_W bits of the register (OUT_W=TOTAL for the whole block)
module simon_word_shifter #(
    parameter int W     = 16,
    parameter int TOTAL = 96,
    parameter int OUT_W = 96
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TOTAL-1:0] load_data,
    input  logic             shift_en,
    input  logic [W-1:0]     shift_in,
    output logic [OUT_W-1:0] data
);

    logic [TOTAL-1:0] shreg_d;
    logic [TOTAL-1:0] shreg_q;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = load_data;
        end else if (shift_en) begin
            shreg_d = {shreg_q[TOTAL-W-1:0], shift_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign data = shreg_q[TOTAL-1 -: OUT_W];

endmodule

// File: rtl/simon_stream_bridge.sv
// Stream bridge for the SIMON_96144 core.
// Packs WORDS input stream words (MS word first) into one 2N-bit block and
// offers it to the core with newData/loadData. When the core raises doneData
// the result is captured with the readData handshake and streamed back out,
// MS word first. The input and output sides run independently.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous reset, active-high
//   bus   simon_stream_bridge_if.slave: input stream, output stream, and the
//         blockIN/newData/loadData and outData/doneData/readData core handshakes
module simon_stream_bridge
    import simon_stream_bridge_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    simon_stream_bridge_if.slave bus
);

    localparam int TOTAL = 2 * N;
    localparam int WORDS = words_per_block(N, W);
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

    // Input side state
    in_state_t     in_state_d, in_state_q;
    logic [CW-1:0] in_count_d, in_count_q;
    logic          in_ready_d, in_ready_q;
    logic          new_data_d, new_data_q;

    // Output side state
    out_state_t    out_state_d, out_state_q;
    logic [CW-1:0] out_count_d, out_count_q;
    logic          out_valid_d, out_valid_q;
    logic          read_data_d, read_data_q;

    logic             in_accept;
    logic             out_accept;
    logic             out_load;
    logic [TOTAL-1:0] pack_data;
    logic [TOTAL-1:0] core_result;
    logic [W-1:0]     unpack_head;

    // in_ready is only ever high in FILL, so it alone qualifies a transfer.
    assign in_accept  = bus.in_valid && in_ready_q;
    assign out_accept = out_valid_q && bus.out_ready;
    assign core_result = bus.outData;

    simon_word_shifter #(
        .W     (W),
        .TOTAL (TOTAL),
        .OUT_W (TOTAL)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ({TOTAL{1'b0}}),
        .shift_en  (in_accept),
        .shift_in  (bus.in_word),
        .data      (pack_data)
    );

    simon_word_shifter #(
        .W     (W),
        .TOTAL (TOTAL),
        .OUT_W (W)
    ) u_unpacker (
        .clk       (clk),
        .rst       (rst),
        .load      (out_load),
        .load_data (core_result),
        .shift_en  (out_accept),
        .shift_in  ({W{1'b0}}),
        .data      (unpack_head)
    );

    // Input FSM next state. in_ready is registered, so it drops in the cycle
    // the FSM enters OFFER and rises again the cycle after loadData is seen.
    // After reset in_ready_q is 0 while the state is already FILL, which gives
    // the one-cycle delay before the first word can be accepted.
    always_comb begin
        in_state_d = in_state_q;
        in_count_d = in_count_q;
        in_ready_d = in_ready_q;
        new_data_d = new_data_q;
        unique case (in_state_q)
            FILL: begin
                in_ready_d = 1'b1;
                new_data_d = 1'b0;
                if (in_accept) begin
                    if (in_count_q == LAST_WORD) begin
                        in_state_d = OFFER;
                        in_ready_d = 1'b0;
                        new_data_d = 1'b1;
                    end else begin
                        in_count_d = in_count_q + 1'b1;
                    end
                end
            end
            OFFER: begin
                in_ready_d = 1'b0;
                new_data_d = 1'b1;
                if (bus.loadData) begin
                    in_state_d = FILL;
                    in_count_d = '0;
                    in_ready_d = 1'b1;
                    new_data_d = 1'b0;
                end
            end
            default: begin
                in_state_d = FILL;
                in_count_d = '0;
                in_ready_d = 1'b0;
                new_data_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_q <= FILL;
            in_count_q <= '0;
            in_ready_q <= 1'b0;
            new_data_q <= 1'b0;
        end else begin
            in_state_q <= in_state_d;
            in_count_q <= in_count_d;
            in_ready_q <= in_ready_d;
            new_data_q <= new_data_d;
        end
    end

    // Output FSM next state. doneData is only looked at in WAIT, so a result
    // arriving while a previous one drains stays pending in the core.
    always_comb begin
        out_state_d = out_state_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        read_data_d = read_data_q;
        out_load    = 1'b0;
        unique case (out_state_q)
            WAIT: begin
                out_valid_d = 1'b0;
                read_data_d = 1'b0;
                if (bus.doneData) begin
                    out_load    = 1'b1;
                    read_data_d = 1'b1;
                    out_state_d = ACK;
                end
            end
            ACK: begin
                read_data_d = 1'b1;
                if (!bus.doneData) begin
                    read_data_d = 1'b0;
                    out_valid_d = 1'b1;
                    out_count_d = '0;
                    out_state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_valid_d = 1'b1;
                if (out_accept) begin
                    if (out_count_q == LAST_WORD) begin
                        out_valid_d = 1'b0;
                        out_count_d = '0;
                        out_state_d = WAIT;
                    end else begin
                        out_count_d = out_count_q + 1'b1;
                    end
                end
            end
            default: begin
                out_state_d = WAIT;
                out_count_d = '0;
                out_valid_d = 1'b0;
                read_data_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_state_q <= WAIT;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            read_data_q <= 1'b0;
        end else begin
            out_state_q <= out_state_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
            read_data_q <= read_data_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.newData   = new_data_q;
    assign bus.blockIN   = pack_data;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = unpack_head;
    assign bus.readData  = read_data_q;

endmodule

// File: tb/tb_simon_stream_bridge.sv
// Self-checking bench for simon_stream_bridge: directed scenarios plus a
// randomized run with concurrent input and output traffic, checked against a
// block model built from plain word concatenation.
module tb_simon_stream_bridge;
    import simon_stream_bridge_pkg::*;

    localparam int N     = 48;
    localparam int W     = 16;
    localparam int WORDS = 6;
    localparam int TOTAL = 96;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    simon_stream_bridge_if #(.N(N), .W(W)) bus ();

    simon_stream_bridge #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: word k of a block sits k words below the top.
    function automatic logic [TOTAL-1:0] pack_words(input logic [W-1:0] w [WORDS]);
        logic [TOTAL-1:0] r;
        r = '0;
        for (int k = 0; k < WORDS; k++) begin
            r = r | (TOTAL'(w[k]) << (TOTAL - W * (k + 1)));
        end
        return r;
    endfunction

    function automatic logic [W-1:0] word_of(input logic [TOTAL-1:0] blk, input int k);
        return W'(blk >> (TOTAL - W * (k + 1)));
    endfunction

    function automatic logic [TOTAL-1:0] block_now();
        block_t b;
        b = bus.blockIN;
        return {b[1], b[0]};
    endfunction

    function automatic logic [TOTAL-1:0] rand_block();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_word   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.loadData  = 1'b0;
        bus.doneData  = 1'b0;
        bus.outData   = '0;
    endtask

    // Offers one word and waits (bounded) until the bridge takes it.
    task automatic push_word(input logic [W-1:0] w);
        int n;
        n = 0;
        bus.in_word  = w;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) begin
            total++;
            bad++;
            $display("[TB] FAIL push_timeout: in_ready stayed %b, need 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        total++; if (bus.newData !== 1'b0) begin bad++; $display("[TB] FAIL reset_newData: got %b want 0", bus.newData); end
        total++; if (bus.readData !== 1'b0) begin bad++; $display("[TB] FAIL reset_readData: got %b want 0", bus.readData); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_word !== 16'h0) begin bad++; $display("[TB] FAIL reset_out_word: got %h want 0", bus.out_word); end
        total++; if (block_now() !== 96'h0) begin bad++; $display("[TB] FAIL reset_blockIN: got %h want 0", block_now()); end
        rst = 1'b0;
        tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_release_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_single_block();
        logic [W-1:0] w [WORDS];
        w = '{16'h7461, 16'h6874, 16'h2074, 16'h7375, 16'h6420, 16'h666F};
        for (int k = 0; k < WORDS - 1; k++) push_word(w[k]);
        total++; if (bus.newData !== 1'b0) begin bad++; $display("[TB] FAIL single_early_newData: got %b want 0", bus.newData); end
        push_word(w[WORDS-1]);
        total++; if (bus.newData !== 1'b1) begin bad++; $display("[TB] FAIL single_newData_latency: got %b want 1", bus.newData); end
        total++; if (block_now() !== 96'h74616874207473756420666F) begin bad++; $display("[TB] FAIL single_blockIN: got %h want 74616874207473756420666F", block_now()); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL single_offer_in_ready: got %b want 0", bus.in_ready); end
        bus.loadData = 1'b1;
        tick();
        bus.loadData = 1'b0;
        total++; if (bus.newData !== 1'b0) begin bad++; $display("[TB] FAIL single_newData_clear: got %b want 0", bus.newData); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_in_ready_back: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_result_return();
        logic [TOTAL-1:0] r;
        logic [W-1:0] ew [WORDS];
        r  = 96'hECAD1C6C451E3F59C5DB1AE9;
        ew = '{16'hECAD, 16'h1C6C, 16'h451E, 16'h3F59, 16'hC5DB, 16'h1AE9};
        bus.outData  = r;
        bus.doneData = 1'b1;
        tick();
        total++; if (bus.readData !== 1'b1) begin bad++; $display("[TB] FAIL result_readData_latency: got %b want 1", bus.readData); end
        tick();
        tick();
        total++; if (bus.readData !== 1'b1) begin bad++; $display("[TB] FAIL result_readData_hold: got %b want 1", bus.readData); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL result_valid_during_ack: got %b want 0", bus.out_valid); end
        bus.doneData = 1'b0;
        tick();
        total++; if (bus.readData !== 1'b0) begin bad++; $display("[TB] FAIL result_readData_drop: got %b want 0", bus.readData); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < WORDS; k++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.out_word !== ew[k]) begin bad++; $display("[TB] FAIL result_word%0d: got v=%b %h want v=1 %h", k, bus.out_valid, bus.out_word, ew[k]); end
            tick();
        end
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL result_valid_end: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [TOTAL-1:0] r1, r2;
        r1 = rand_block();
        r2 = rand_block();
        bus.outData  = r1;
        bus.doneData = 1'b1;
        tick();
        bus.doneData = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            total++; if (bus.out_word !== word_of(r1, k)) begin bad++; $display("[TB] FAIL bp_word%0d: got %h want %h", k, bus.out_word, word_of(r1, k)); end
            tick();
        end
        bus.out_ready = 1'b0;
        bus.outData   = r2;
        bus.doneData  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++; if (bus.out_valid !== 1'b1 || bus.out_word !== word_of(r1, 2)) begin bad++; $display("[TB] FAIL bp_stall%0d: got v=%b %h want v=1 %h", c, bus.out_valid, bus.out_word, word_of(r1, 2)); end
            total++; if (bus.readData !== 1'b0) begin bad++; $display("[TB] FAIL bp_early_ack%0d: got %b want 0", c, bus.readData); end
        end
        bus.out_ready = 1'b1;
        for (int k = 2; k < WORDS; k++) begin
            total++; if (bus.out_word !== word_of(r1, k) || bus.readData !== 1'b0) begin bad++; $display("[TB] FAIL bp_rest%0d: got %h rd=%b want %h rd=0", k, bus.out_word, bus.readData, word_of(r1, k)); end
            tick();
        end
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0 || bus.readData !== 1'b0) begin bad++; $display("[TB] FAIL bp_after_drain: got v=%b rd=%b want 0 0", bus.out_valid, bus.readData); end
        tick();
        total++; if (bus.readData !== 1'b1) begin bad++; $display("[TB] FAIL bp_second_ack: got %b want 1", bus.readData); end
        bus.doneData = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        for (int k = 0; k < WORDS; k++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.out_word !== word_of(r2, k)) begin bad++; $display("[TB] FAIL bp_second_word%0d: got v=%b %h want %h", k, bus.out_valid, bus.out_word, word_of(r2, k)); end
            tick();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_core_stall();
        logic [W-1:0] w [WORDS];
        logic [TOTAL-1:0] exp;
        for (int k = 0; k < WORDS; k++) w[k] = W'($urandom());
        exp = pack_words(w);
        for (int k = 0; k < WORDS; k++) push_word(w[k]);
        bus.in_word  = 16'hBEEF;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            total++; if (bus.newData !== 1'b1 || bus.in_ready !== 1'b0 || block_now() !== exp) begin bad++; $display("[TB] FAIL stall_hold%0d: got nd=%b rdy=%b %h want nd=1 rdy=0 %h", c, bus.newData, bus.in_ready, block_now(), exp); end
            tick();
        end
        bus.loadData = 1'b1;
        tick();
        bus.loadData = 1'b0;
        bus.in_valid = 1'b0;
        total++; if (bus.newData !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stall_release: got nd=%b rdy=%b want 0 1", bus.newData, bus.in_ready); end
        for (int k = 0; k < WORDS; k++) w[k] = W'($urandom());
        exp = pack_words(w);
        for (int k = 0; k < WORDS; k++) push_word(w[k]);
        total++; if (bus.newData !== 1'b1 || block_now() !== exp) begin bad++; $display("[TB] FAIL stall_next_block: got nd=%b %h want nd=1 %h", bus.newData, block_now(), exp); end
        bus.loadData = 1'b1;
        tick();
        bus.loadData = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w [WORDS];
        logic [TOTAL-1:0] exp;
        for (int k = 0; k < 3; k++) push_word(W'($urandom()));
        rst = 1'b1;
        tick();
        total++; if (bus.in_ready !== 1'b0 || block_now() !== 96'h0 || bus.newData !== 1'b0) begin bad++; $display("[TB] FAIL rstfill_outputs: got rdy=%b nd=%b %h want 0 0 0", bus.in_ready, bus.newData, block_now()); end
        rst = 1'b0;
        tick();
        bus.outData  = rand_block();
        bus.doneData = 1'b1;
        tick();
        bus.doneData = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.readData !== 1'b0 || bus.out_word !== 16'h0) begin bad++; $display("[TB] FAIL rstdrain_outputs: got v=%b rd=%b %h want 0 0 0", bus.out_valid, bus.readData, bus.out_word); end
        rst = 1'b0;
        tick();
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_after: got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
        for (int k = 0; k < WORDS; k++) w[k] = W'($urandom());
        exp = pack_words(w);
        for (int k = 0; k < WORDS; k++) push_word(w[k]);
        total++; if (bus.newData !== 1'b1 || block_now() !== exp) begin bad++; $display("[TB] FAIL rst_fresh_block: got nd=%b %h want nd=1 %h", bus.newData, block_now(), exp); end
        bus.loadData = 1'b1;
        tick();
        bus.loadData = 1'b0;
    endtask

    task automatic test_random_traffic();
        fork
            begin
                logic [W-1:0] w [WORDS];
                logic [TOTAL-1:0] exp;
                for (int b = 0; b < 8; b++) begin
                    for (int k = 0; k < WORDS; k++) w[k] = W'($urandom());
                    exp = pack_words(w);
                    for (int k = 0; k < WORDS; k++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        push_word(w[k]);
                    end
                    total++; if (bus.newData !== 1'b1 || block_now() !== exp) begin bad++; $display("[TB] FAIL rnd_block%0d: got nd=%b %h want nd=1 %h", b, bus.newData, block_now(), exp); end
                    repeat ($urandom_range(0, 4)) tick();
                    bus.loadData = 1'b1;
                    tick();
                    bus.loadData = 1'b0;
                end
            end
            begin
                logic [TOTAL-1:0] r;
                int idx;
                int n;
                for (int b = 0; b < 8; b++) begin
                    r = rand_block();
                    bus.outData  = r;
                    bus.doneData = 1'b1;
                    n = 0;
                    while (!bus.readData && n < 50) begin tick(); n++; end
                    if (n >= 50) begin total++; bad++; $display("[TB] FAIL rnd_ack_timeout%0d: readData %b want 1", b, bus.readData); end
                    repeat ($urandom_range(0, 2)) tick();
                    bus.doneData = 1'b0;
                    idx = 0;
                    n   = 0;
                    while (idx < WORDS && n < 300) begin
                        bus.out_ready = 1'($urandom_range(0, 1));
                        if (bus.out_valid && bus.out_ready) begin
                            total++; if (bus.out_word !== word_of(r, idx)) begin bad++; $display("[TB] FAIL rnd_out%0d_%0d: got %h want %h", b, idx, bus.out_word, word_of(r, idx)); end
                            idx++;
                        end
                        tick();
                        n++;
                    end
                    bus.out_ready = 1'b0;
                    if (idx < WORDS) begin total++; bad++; $display("[TB] FAIL rnd_drain_timeout%0d: got %0d words want %0d", b, idx, WORDS); end
                end
            end
        join
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_block();
        test_result_return();
        test_backpressure();
        test_core_stall();
        test_reset_mid();
        test_random_traffic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
